// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-lane TDM receiver: serial sample side in, assembled frame side out.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   d_in;
  logic               valid_in;
  logic               frame_in;
  logic [4*WIDTH-1:0] y_out;
  logic               frame_valid_out;
  logic [1:0]         slot_out;
  logic               locked_out;
  logic               err_out;

  modport master (
    output d_in, valid_in, frame_in,
    input  y_out, frame_valid_out, slot_out, locked_out, err_out
  );

  modport slave (
    input  d_in, valid_in, frame_in,
    output y_out, frame_valid_out, slot_out, locked_out, err_out
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot TDM link: locks on the slot-0 marker, collects four lanes
// into a parallel word and flags framing errors.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input logic         clock,
  input logic         reset,
  tdm_demux4_if.slave bus
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t             state, state_n;
  logic [1:0]         slot, slot_n;
  logic [WIDTH-1:0]   lane0, lane1, lane2;
  logic [WIDTH-1:0]   lane0_n, lane1_n, lane2_n;
  logic [4*WIDTH-1:0] y, y_n;
  logic               fv, fv_n;
  logic               err, err_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      slot  <= '0;
      lane0 <= '0;
      lane1 <= '0;
      lane2 <= '0;
      y     <= '0;
      fv    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      lane0 <= lane0_n;
      lane1 <= lane1_n;
      lane2 <= lane2_n;
      y     <= y_n;
      fv    <= fv_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    slot_n  = slot;
    lane0_n = lane0;
    lane1_n = lane1;
    lane2_n = lane2;
    y_n     = y;
    fv_n    = 1'b0;
    err_n   = 1'b0;

    if (bus.valid_in) begin
      unique case (state)
        HUNT: begin
          if (bus.frame_in) begin
            lane0_n = bus.d_in;
            slot_n  = 2'd1;
            state_n = LOCK;
          end
        end
        LOCK: begin
          if (bus.frame_in) begin
            // A marker always restarts the frame; off slot 0 it also discards the partial one.
            err_n   = (slot != 2'd0);
            lane0_n = bus.d_in;
            slot_n  = 2'd1;
          end else begin
            unique case (slot)
              2'd0: begin
                err_n   = 1'b1;
                state_n = HUNT;
              end
              2'd1: begin
                lane1_n = bus.d_in;
                slot_n  = 2'd2;
              end
              2'd2: begin
                lane2_n = bus.d_in;
                slot_n  = 2'd3;
              end
              2'd3: begin
                y_n    = {bus.d_in, lane2, lane1, lane0};
                fv_n   = 1'b1;
                slot_n = 2'd0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.y_out           = y;
  assign bus.frame_valid_out = fv;
  assign bus.slot_out        = slot;
  assign bus.locked_out      = (state == LOCK);
  assign bus.err_out         = err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed-vector bench for tdm_demux4 with WIDTH=4 and hand-computed expectations.
module tb_tdm_demux4;

  localparam int WIDTH = 4;

  logic clock;
  logic reset;
  int   nvec;
  int   nmis;
  int   fv_count;

  tdm_demux4_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and sample registered outputs just after the edge.
  task automatic step(input logic [WIDTH-1:0] d, input logic v, input logic f);
    bus.d_in     = d;
    bus.valid_in = v;
    bus.frame_in = f;
    @(posedge clock);
    #1;
    if (bus.frame_valid_out) fv_count++;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] y, input logic fv,
                         input logic [1:0] slot, input logic lk, input logic er);
    chk({tag, ".y"},    32'(bus.y_out), 32'(y));
    chk({tag, ".fv"},   32'(bus.frame_valid_out), 32'(fv));
    chk({tag, ".slot"}, 32'(bus.slot_out), 32'(slot));
    chk({tag, ".lock"}, 32'(bus.locked_out), 32'(lk));
    chk({tag, ".err"},  32'(bus.err_out), 32'(er));
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    chk_all("rst", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    nvec     = 0;
    nmis     = 0;
    fv_count = 0;
    reset        = 1'b1;
    bus.d_in     = '0;
    bus.valid_in = 1'b0;
    bus.frame_in = 1'b0;
    #2;
    chk_all("init", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    #10;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic frame
    step(4'hA, 1'b1, 1'b1); chk_all("b0", 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0);
    step(4'h5, 1'b1, 1'b0); chk_all("b1", 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0); chk_all("b2", 16'h0000, 1'b0, 2'd3, 1'b1, 1'b0);
    step(4'hC, 1'b1, 1'b0); chk_all("b3", 16'hC35A, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b0); chk_all("b4", 16'hC35A, 1'b0, 2'd0, 1'b1, 1'b0);

    // Mid-stream reset with random data, partial frame in progress
    step(4'(($urandom)), 1'b1, 1'b1);
    step(4'(($urandom)), 1'b1, 1'b0);
    bus.d_in = 4'($urandom);
    do_reset();

    // Hunt discard: unmarked samples are dropped
    step(4'h1, 1'b1, 1'b0); chk_all("h0", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step(4'h2, 1'b1, 1'b0); chk_all("h1", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step(4'h4, 1'b1, 1'b1); chk_all("h2", 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0);
    step(4'h1, 1'b1, 1'b0); chk_all("h5", 16'h1234, 1'b1, 2'd0, 1'b1, 1'b0);

    // Idle gaps with stray markers
    fv_count = 0;
    begin
      logic [WIDTH-1:0] seq [4];
      seq = '{4'hA, 4'h5, 4'h3, 4'hC};
      for (int i = 0; i < 4; i++) begin
        step(seq[i], 1'b1, (i == 0));
        if (i < 3) begin
          for (int j = 0; j < 3; j++) begin
            step(4'hF, 1'b0, 1'b1);
            chk("gap.err", 32'(bus.err_out), 32'd0);
          end
          chk("gap.slot", 32'(bus.slot_out), 32'(i + 1));
          chk("gap.y", 32'(bus.y_out), 32'h1234);
        end
      end
    end
    chk_all("g.end", 16'hC35A, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    chk("g.pulses", 32'(fv_count), 32'd1);

    // Early marker resync
    step(4'hA, 1'b1, 1'b1);
    step(4'h5, 1'b1, 1'b0);
    step(4'h7, 1'b1, 1'b1); chk_all("e0", 16'hC35A, 1'b0, 2'd1, 1'b1, 1'b1);
    step(4'h8, 1'b1, 1'b0); chk_all("e1", 16'hC35A, 1'b0, 2'd2, 1'b1, 1'b0);
    step(4'h9, 1'b1, 1'b0); chk_all("e2", 16'hC35A, 1'b0, 2'd3, 1'b1, 1'b0);
    step(4'hB, 1'b1, 1'b0); chk_all("e3", 16'hB987, 1'b1, 2'd0, 1'b1, 1'b0);

    // Early marker on slot 3: partial frame must not reach y_out
    step(4'h1, 1'b1, 1'b1);
    step(4'h2, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    step(4'hD, 1'b1, 1'b1); chk_all("e4", 16'hB987, 1'b0, 2'd1, 1'b1, 1'b1);
    step(4'hE, 1'b1, 1'b0);
    step(4'h6, 1'b1, 1'b0);
    step(4'h5, 1'b1, 1'b0); chk_all("e5", 16'h56ED, 1'b1, 2'd0, 1'b1, 1'b0);

    // Lost lock
    step(4'hF, 1'b1, 1'b0); chk_all("l0", 16'h56ED, 1'b0, 2'd0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0); chk_all("l1", 16'h56ED, 1'b0, 2'd0, 1'b0, 1'b0);
    step(4'h6, 1'b1, 1'b1); chk_all("l2", 16'h56ED, 1'b0, 2'd1, 1'b1, 1'b0);
    step(4'h7, 1'b1, 1'b0);
    step(4'h8, 1'b1, 1'b0);
    step(4'h9, 1'b1, 1'b0); chk_all("l3", 16'h9876, 1'b1, 2'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of a 4-channel time-division-multiplexed link: the counterpart of the 4:1 mux, where a transmitter cycles its select 0..3 and sends one lane per valid cycle.
- Accepts a serial sample stream with a frame marker on slot 0.
- Tracks the slot position and collects the four lanes into a parallel word.
- Presents the word with a one-cycle valid strobe; detects framing errors.

Parameters:
- WIDTH, 1, bit width of one lane sample (d_in and each lane of y_out).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- d_in  input  WIDTH  serial sample for the current slot.
- valid_in  input  1  d_in and frame_in are qualified this cycle.
- frame_in  input  1  marks the sample as slot 0; only meaningful when valid_in=1.
- y_out  output  4*WIDTH  assembled frame; lane k at y_out[k*WIDTH +: WIDTH].
- frame_valid_out  output  1  one-cycle pulse when y_out updates.
- slot_out  output  2  slot index the next accepted sample will fill.
- locked_out  output  1  1 when the state is LOCK.
- err_out  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (asynchronous, immediate):
  - y_out=0, frame_valid_out=0, slot_out=0, locked_out=0, err_out=0.
  - Internal lane registers 0..2 are cleared.
  - State is HUNT.
- Registered outputs: all outputs are registered. Nothing changes on a cycle with valid_in=0, except that the frame_valid_out and err_out pulses self-clear.
- State HUNT:
  - Samples without frame_in are dropped; slot_out stays 0.
  - On valid_in=1 with frame_in=1: store d_in in lane 0, set slot to 1, go to LOCK, locked_out=1 next cycle.
- State LOCK, valid_in=1, slot=0, frame_in=1 (normal): store d_in in lane 0, slot becomes 1.
- State LOCK, valid_in=1, slot=1 or 2, frame_in=0 (normal): store d_in in that lane, slot increments.
- State LOCK, valid_in=1, slot=3, frame_in=0 (frame complete):
  - On that edge, y_out <= {d_in, lane2, lane1, lane0} and frame_valid_out=1 for exactly one cycle.
  - Slot wraps to 0.
  - Latency: y_out and frame_valid_out are visible the cycle after the slot-3 sample is accepted.
- State LOCK, valid_in=1, slot≠0, frame_in=1 (early marker, resync):
  - err_out pulses for one cycle.
  - The partial frame is discarded and y_out is not updated.
  - d_in is stored as lane 0, slot becomes 1; remain in LOCK.
- State LOCK, valid_in=1, slot=0, frame_in=0 (missing marker, lost lock):
  - err_out pulses for one cycle.
  - The sample is dropped; go to HUNT with slot_out=0, locked_out=0.
- valid_in=0 gaps: slot, lanes and state hold indefinitely. A frame may span any number of idle cycles.
- frame_in with valid_in=0 is ignored in both states.
- Lane storage:
  - Lane registers are overwritten only on acceptance.
  - Stale lane contents from an aborted frame never reach y_out; every y_out update follows a full fresh 0..3 sequence.
- Event precedence on one edge: reset > early-marker resync > normal accept.
- Mid-frame reset: partial data is lost and the block re-enters HUNT. The first frame_valid_out after reset requires a new frame_in.
- Widths: the slot counter is 2 bits and wraps 3→0 naturally. The block does no arithmetic on data.

Test Plan (WIDTH=4):
- Reset check:
  - Stimulus: assert reset mid-stream with random inputs.
  - Required: all outputs become 0 immediately, without waiting for a clock edge; locked_out=0.
- Basic frame:
  - Stimulus: after reset, valid_in=1 back-to-back with d_in 4'hA (frame_in=1), 4'h5, 4'h3, 4'hC.
  - Required: the cycle after 4'hC, y_out=16'hC35A and frame_valid_out=1 for one cycle; slot_out sequence 1,2,3,0; locked_out=1 from the second cycle.
- Hunt discard:
  - Stimulus: send 4'h1, 4'h2 with frame_in=0, then a normal frame 4'h4, 4'h3, 4'h2, 4'h1 (marker on 4'h4).
  - Required: no output during the 4'h1/4'h2 samples; y_out=16'h1234 after the last sample.
- Idle gaps:
  - Stimulus: the same frame as the basic-frame test, with 3 idle cycles (valid_in=0, frame_in=1) inserted between each sample.
  - Required: identical y_out=16'hC35A and a single frame_valid_out pulse; the stray frame_in during idle cycles causes no err_out.
- Early marker:
  - Stimulus: 4'hA (frame_in=1), 4'h5, then 4'h7 (frame_in=1), 4'h8, 4'h9, 4'hB.
  - Required: err_out pulses after 4'h7; no frame_valid_out for the aborted frame; y_out=16'hB987 after 4'hB.
- Lost lock:
  - Stimulus: complete one frame, then 4'hF with frame_in=0, followed by a valid frame.
  - Required: err_out pulses and locked_out=0 after 4'hF; the next frame is assembled correctly after re-lock.
